// File: rtl/tlb_assoc.sv
// Fully-associative TLB with true-LRU replacement, per-entry write permission,
// miss/refill handshake and supervisor-mode bypass.
module tlb_assoc #(
    parameter int unsigned ENTRIES  = 4,
    parameter int unsigned VA_W     = 32,
    parameter int unsigned OFFSET_W = 12,
    parameter int unsigned PPN_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [VA_W-1:0]              req_vaddr,
    input  logic                         req_write,
    input  logic                         supervisor_mode,
    output logic                         resp_valid,
    output logic [PPN_W+OFFSET_W-1:0]    resp_paddr,
    output logic                         resp_fault,
    output logic                         miss_valid,
    output logic [VA_W-OFFSET_W-1:0]     miss_vpn,
    input  logic                         refill_valid,
    input  logic [PPN_W-1:0]             refill_ppn,
    input  logic                         refill_writable,
    output logic                         refill_ready,
    output logic                         fetch
);

    localparam int unsigned PA_W  = PPN_W + OFFSET_W;
    localparam int unsigned VPN_W = VA_W - OFFSET_W;
    localparam int unsigned AGE_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Entry storage
    logic [VPN_W-1:0]   ent_vpn [ENTRIES];
    logic [PPN_W-1:0]   ent_ppn [ENTRIES];
    logic [AGE_W-1:0]   ent_age [ENTRIES];
    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_wr;

    // Request offset and store flag captured on a miss for the refill response
    logic [OFFSET_W-1:0] lat_off_q;
    logic [OFFSET_W-1:0] lat_off_d;
    logic                lat_wr_q;
    logic                lat_wr_d;

    // Next values of the registered outputs
    logic                resp_valid_d;
    logic [PA_W-1:0]     resp_paddr_d;
    logic                resp_fault_d;
    logic                miss_valid_d;
    logic [VPN_W-1:0]    miss_vpn_d;
    logic                fetch_d;

    // Entry update strobes
    logic                fill_en;
    logic                touch_en;
    logic [AGE_W-1:0]    touch_idx;

    logic [VPN_W-1:0]    req_vpn;
    logic [ENTRIES-1:0]  hit_vec;
    logic                hit;
    logic [AGE_W-1:0]    hit_idx;
    logic [AGE_W-1:0]    vic_idx;
    logic                found_free;

    assign req_vpn      = req_vaddr[VA_W-1:OFFSET_W];
    assign hit          = |hit_vec;
    assign req_ready    = (state_q == S_IDLE) && !flush;
    assign refill_ready = miss_valid;

    // Associative match of the request VPN against every valid entry
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (ent_valid[i] && (ent_vpn[i] == req_vpn)) begin
                hit_vec[i] = 1'b1;
            end
        end
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = AGE_W'(i);
            end
        end
    end

    // Victim: lowest-index free entry, otherwise the least recently used one
    always_comb begin
        vic_idx    = '0;
        found_free = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                vic_idx    = AGE_W'(i);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (ent_age[i] == AGE_W'(ENTRIES - 1)) begin
                    vic_idx = AGE_W'(i);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !supervisor_mode && !hit) begin
                        state_d = S_MISS;
                    end
                end
                S_MISS: begin
                    if (refill_valid) begin
                        state_d = S_RESP;
                    end
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and entry-update decode for the coming edge
    always_comb begin
        resp_valid_d = 1'b0;
        resp_paddr_d = resp_paddr;
        resp_fault_d = resp_fault;
        miss_valid_d = miss_valid;
        miss_vpn_d   = miss_vpn;
        fetch_d      = fetch;
        lat_off_d    = lat_off_q;
        lat_wr_d     = lat_wr_q;
        fill_en      = 1'b0;
        touch_en     = 1'b0;
        touch_idx    = '0;
        if (flush) begin
            miss_valid_d = 1'b0;
            fetch_d      = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (supervisor_mode) begin
                            resp_valid_d = 1'b1;
                            resp_paddr_d = req_vaddr[PA_W-1:0];
                            resp_fault_d = 1'b0;
                        end else if (hit) begin
                            resp_valid_d = 1'b1;
                            resp_paddr_d = {ent_ppn[hit_idx], req_vaddr[OFFSET_W-1:0]};
                            resp_fault_d = req_write & ~ent_wr[hit_idx];
                            touch_en     = 1'b1;
                            touch_idx    = hit_idx;
                        end else begin
                            miss_valid_d = 1'b1;
                            miss_vpn_d   = req_vpn;
                            fetch_d      = 1'b0;
                            lat_off_d    = req_vaddr[OFFSET_W-1:0];
                            lat_wr_d     = req_write;
                        end
                    end
                end
                S_MISS: begin
                    if (refill_valid) begin
                        fill_en      = 1'b1;
                        touch_en     = 1'b1;
                        touch_idx    = vic_idx;
                        miss_valid_d = 1'b0;
                        fetch_d      = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_paddr_d = {refill_ppn, lat_off_q};
                        resp_fault_d = lat_wr_q & ~refill_writable;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs and miss context
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_paddr <= '0;
            resp_fault <= 1'b0;
            miss_valid <= 1'b0;
            miss_vpn   <= '0;
            fetch      <= 1'b1;
            lat_off_q  <= '0;
            lat_wr_q   <= 1'b0;
        end else begin
            resp_valid <= resp_valid_d;
            resp_paddr <= resp_paddr_d;
            resp_fault <= resp_fault_d;
            miss_valid <= miss_valid_d;
            miss_vpn   <= miss_vpn_d;
            fetch      <= fetch_d;
            lat_off_q  <= lat_off_d;
            lat_wr_q   <= lat_wr_d;
        end
    end

    // Entry array: refill write and LRU age update (ages stay a permutation)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_wr    <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ent_vpn[i] <= '0;
                ent_ppn[i] <= '0;
                ent_age[i] <= AGE_W'(i);
            end
        end else if (flush) begin
            ent_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ent_age[i] <= AGE_W'(i);
            end
        end else begin
            if (fill_en) begin
                ent_vpn[vic_idx]   <= miss_vpn;
                ent_ppn[vic_idx]   <= refill_ppn;
                ent_wr[vic_idx]    <= refill_writable;
                ent_valid[vic_idx] <= 1'b1;
            end
            if (touch_en) begin
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    if (AGE_W'(i) == touch_idx) begin
                        ent_age[i] <= '0;
                    end else if (ent_age[i] < ent_age[touch_idx]) begin
                        ent_age[i] <= ent_age[i] + AGE_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_assoc.sv
// Self-checking bench for tlb_assoc: directed scenarios plus random traffic,
// checked every cycle against a recency-list model of the TLB.
module tb_tlb_assoc;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic [31:0] vaddr;
    logic        req_write;
    logic        sup;
    logic        refill_valid;
    logic [19:0] refill_ppn;
    logic        refill_wr;
    logic        sel;  // 0: 4-entry/PPN_W=8 instance, 1: 8-entry/PPN_W=20 instance

    logic        a_req_ready, a_resp_valid, a_resp_fault, a_miss_valid, a_refill_ready, a_fetch;
    logic [19:0] a_resp_paddr;
    logic [19:0] a_miss_vpn;
    logic        b_req_ready, b_resp_valid, b_resp_fault, b_miss_valid, b_refill_ready, b_fetch;
    logic [31:0] b_resp_paddr;
    logic [19:0] b_miss_vpn;

    tlb_assoc #(.ENTRIES(4), .VA_W(32), .OFFSET_W(12), .PPN_W(8)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_vaddr(vaddr),
        .req_write(req_write), .supervisor_mode(sup),
        .resp_valid(a_resp_valid), .resp_paddr(a_resp_paddr), .resp_fault(a_resp_fault),
        .miss_valid(a_miss_valid), .miss_vpn(a_miss_vpn),
        .refill_valid(refill_valid & ~sel), .refill_ppn(refill_ppn[7:0]),
        .refill_writable(refill_wr), .refill_ready(a_refill_ready), .fetch(a_fetch)
    );

    tlb_assoc #(.ENTRIES(8), .VA_W(32), .OFFSET_W(12), .PPN_W(20)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_vaddr(vaddr),
        .req_write(req_write), .supervisor_mode(sup),
        .resp_valid(b_resp_valid), .resp_paddr(b_resp_paddr), .resp_fault(b_resp_fault),
        .miss_valid(b_miss_valid), .miss_vpn(b_miss_vpn),
        .refill_valid(refill_valid & sel), .refill_ppn(refill_ppn),
        .refill_writable(refill_wr), .refill_ready(b_refill_ready), .fetch(b_fetch)
    );

    wire        c_req_ready  = sel ? b_req_ready    : a_req_ready;
    wire        c_resp_valid = sel ? b_resp_valid   : a_resp_valid;
    wire [31:0] c_resp_paddr = sel ? b_resp_paddr   : {12'b0, a_resp_paddr};
    wire        c_resp_fault = sel ? b_resp_fault   : a_resp_fault;
    wire        c_miss_valid = sel ? b_miss_valid   : a_miss_valid;
    wire [19:0] c_miss_vpn   = sel ? b_miss_vpn     : a_miss_vpn;
    wire        c_refill_rdy = sel ? b_refill_ready : a_refill_ready;
    wire        c_fetch      = sel ? b_fetch        : a_fetch;

    int checks = 0;
    int errors = 0;

    // Behavioural model: entry table plus a recency list (front = most recent)
    int          n;
    int          ppn_w;
    logic [19:0] m_vpn [8];
    logic [31:0] m_ppn [8];
    bit          m_wr  [8];
    bit          m_val [8];
    int          order [$];
    int          m_state;  // 0 idle, 1 waiting for refill, 2 refill response
    logic [11:0] m_off;
    bit          m_w;
    logic        e_rv;
    logic [31:0] e_pa;
    logic        e_fault;
    logic        e_mv;
    logic [19:0] e_mvpn;
    logic        e_fetch;

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Literal expectation checked against both the DUT and the model
    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] exp);
        chk(name, dut_v, exp);
        chk({"model_", name}, mdl_v, exp);
    endtask

    function automatic logic [31:0] pa_mask();
        int pw = ppn_w + 12;
        return (pw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << pw) - 32'h1);
    endfunction

    function automatic logic [31:0] ppn_mask();
        return (32'h1 << ppn_w) - 32'h1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) m_val[i] = 1'b0;
        order.delete();
        for (int i = 0; i < n; i++) order.push_back(i);
    endfunction

    function automatic void m_init();
        n     = sel ? 8 : 4;
        ppn_w = sel ? 20 : 8;
        m_clear();
        m_state = 0;
        e_rv = 1'b0; e_pa = '0; e_fault = 1'b0; e_mv = 1'b0; e_mvpn = '0; e_fetch = 1'b1;
        m_off = '0; m_w = 1'b0;
    endfunction

    function automatic void touch(input int k);
        int pos = -1;
        for (int j = 0; j < order.size(); j++) if (order[j] == k) pos = j;
        if (pos >= 0) order.delete(pos);
        order.push_front(k);
    endfunction

    task automatic m_step();
        int          hidx;
        int          v;
        logic [19:0] rvpn;
        if (flush) begin
            m_clear();
            m_state = 0; e_mv = 1'b0; e_fetch = 1'b1; e_rv = 1'b0;
            return;
        end
        e_rv = 1'b0;
        case (m_state)
            0: if (req_valid) begin
                rvpn = vaddr[31:12];
                if (sup) begin
                    e_rv = 1'b1; e_pa = vaddr & pa_mask(); e_fault = 1'b0;
                end else begin
                    hidx = -1;
                    for (int i = 0; i < n; i++) if (m_val[i] && m_vpn[i] == rvpn) hidx = i;
                    if (hidx >= 0) begin
                        e_rv    = 1'b1;
                        e_pa    = ((m_ppn[hidx] << 12) | {20'b0, vaddr[11:0]}) & pa_mask();
                        e_fault = req_write && !m_wr[hidx];
                        touch(hidx);
                    end else begin
                        m_state = 1; e_mv = 1'b1; e_mvpn = rvpn; e_fetch = 1'b0;
                        m_off = vaddr[11:0]; m_w = req_write;
                    end
                end
            end
            1: if (refill_valid) begin
                v = -1;
                for (int i = n - 1; i >= 0; i--) if (!m_val[i]) v = i;
                if (v < 0) v = order[order.size() - 1];
                m_vpn[v] = e_mvpn;
                m_ppn[v] = {12'b0, refill_ppn} & ppn_mask();
                m_wr[v]  = refill_wr;
                m_val[v] = 1'b1;
                touch(v);
                m_state = 2; e_mv = 1'b0; e_fetch = 1'b1; e_rv = 1'b1;
                e_pa    = ((m_ppn[v] << 12) | {20'b0, m_off}) & pa_mask();
                e_fault = m_w && !refill_wr;
            end
            default: m_state = 0;
        endcase
    endtask

    // Model advances on every active edge outside reset
    initial forever begin
        @(posedge clk);
        if (reset) m_step();
    end

    // Per-cycle comparison of the selected DUT against the model
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            chk("req_ready",    32'(c_req_ready),  32'((m_state == 0) && !flush));
            chk("resp_valid",   32'(c_resp_valid), 32'(e_rv));
            chk("resp_paddr",   c_resp_paddr,      e_pa);
            chk("resp_fault",   32'(c_resp_fault), 32'(e_fault));
            chk("miss_valid",   32'(c_miss_valid), 32'(e_mv));
            chk("refill_ready", 32'(c_refill_rdy), 32'(e_mv));
            chk("fetch",        32'(c_fetch),      32'(e_fetch));
            if (e_mv) chk("miss_vpn", 32'(c_miss_vpn), 32'(e_mvpn));
            chk("multi_hit_a", 32'($countones(dut_a.hit_vec) > 1), 32'd0);
            chk("multi_hit_b", 32'($countones(dut_b.hit_vec) > 1), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 1'b0; sup = 1'b0; req_write = 1'b0; refill_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic access(input logic [31:0] va, input bit w, input bit s);
        req_valid = 1'b1; vaddr = va; req_write = w; sup = s;
        cyc();
        req_valid = 1'b0; req_write = 1'b0; sup = 1'b0;
    endtask

    task automatic refill(input logic [19:0] p, input bit w);
        refill_valid = 1'b1; refill_ppn = p; refill_wr = w;
        cyc();
        refill_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        m_init();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    // Fill all entries, touch VPN 1, miss once more: VPN 2 must be evicted
    task automatic fill_replace(input int ne, input logic [19:0] base);
        logic [31:0] pa;
        do_flush();
        for (int v = 1; v <= ne; v++) begin
            access({20'(v), 12'h100}, 1'b0, 1'b0);
            chk("fill_miss", 32'(c_miss_valid), 32'd1);
            refill(base + 20'(v), 1'b1);
            cyc();
        end
        access({20'd1, 12'h123}, 1'b0, 1'b0);
        pa = ({12'b0, base + 20'd1} << 12) | 32'h123;
        lit("touch_hit", 32'(c_resp_valid), 32'(e_rv), 32'd1);
        lit("touch_pa", c_resp_paddr, e_pa, pa);
        access({20'(ne + 1), 12'h456}, 1'b0, 1'b0);
        lit("new_miss_vpn", 32'(c_miss_vpn), 32'(e_mvpn), 32'(ne + 1));
        refill(base + 20'(ne + 1), 1'b1);
        pa = ({12'b0, base + 20'(ne + 1)} << 12) | 32'h456;
        lit("replace_pa", c_resp_paddr, e_pa, pa);
        cyc();
        access({20'd1, 12'h124}, 1'b0, 1'b0);
        lit("vpn1_kept", 32'(c_resp_valid), 32'(e_rv), 32'd1);
        access({20'd2, 12'h000}, 1'b0, 1'b0);
        lit("vpn2_evicted", 32'(c_miss_valid), 32'(e_mv), 32'd1);
        refill(base + 20'd2, 1'b1);
        cyc();
    endtask

    task automatic rand_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            req_valid    = ($urandom_range(0, 2) != 0);
            sup          = ($urandom_range(0, 7) == 0);
            req_write    = 1'($urandom_range(0, 1));
            vaddr        = sup ? $urandom : {20'($urandom_range(0, 11)), 12'($urandom)};
            refill_valid = ($urandom_range(0, 2) == 0);
            refill_ppn   = 20'($urandom);
            refill_wr    = 1'($urandom_range(0, 1));
            flush        = ($urandom_range(0, 59) == 0);
            cyc();
        end
        idle_in();
        repeat (2) cyc();
    endtask

    initial begin
        sel = 1'b0; vaddr = '0; refill_ppn = '0; refill_wr = 1'b0;
        do_reset();

        // Reset values after release
        lit("rst_req_ready", 32'(c_req_ready), 32'((m_state == 0) && !flush), 32'd1);
        lit("rst_resp_valid", 32'(c_resp_valid), 32'(e_rv), 32'd0);
        lit("rst_paddr", c_resp_paddr, e_pa, 32'd0);
        lit("rst_miss_valid", 32'(c_miss_valid), 32'(e_mv), 32'd0);
        lit("rst_miss_vpn", 32'(c_miss_vpn), 32'(e_mvpn), 32'd0);
        lit("rst_fetch", 32'(c_fetch), 32'(e_fetch), 32'd1);

        // Supervisor bypass
        access(32'h0001_2345, 1'b0, 1'b1);
        lit("sup_valid", 32'(c_resp_valid), 32'(e_rv), 32'd1);
        lit("sup_pa", c_resp_paddr, e_pa, 32'h12345);
        lit("sup_fetch", 32'(c_fetch), 32'(e_fetch), 32'd1);

        // First user access misses, refill, then repeat hits
        access(32'h0000_5ABC, 1'b0, 1'b0);
        lit("miss_valid", 32'(c_miss_valid), 32'(e_mv), 32'd1);
        lit("miss_vpn", 32'(c_miss_vpn), 32'(e_mvpn), 32'h5);
        lit("miss_fetch", 32'(c_fetch), 32'(e_fetch), 32'd0);
        refill(20'h3C, 1'b1);
        lit("refill_resp", 32'(c_resp_valid), 32'(e_rv), 32'd1);
        lit("refill_pa", c_resp_paddr, e_pa, 32'h3CABC);
        lit("refill_fetch", 32'(c_fetch), 32'(e_fetch), 32'd1);
        cyc();
        access(32'h0000_5ABC, 1'b0, 1'b0);
        lit("repeat_hit", 32'(c_resp_valid), 32'(e_rv), 32'd1);
        lit("repeat_pa", c_resp_paddr, e_pa, 32'h3CABC);

        fill_replace(4, 20'h10);

        // Write permission fault
        do_flush();
        access(32'h0000_7123, 1'b1, 1'b0);
        refill(20'h2A, 1'b0);
        lit("ro_refill_fault", 32'(c_resp_fault), 32'(e_fault), 32'd1);
        lit("ro_refill_pa", c_resp_paddr, e_pa, 32'h2A123);
        cyc();
        access(32'h0000_7123, 1'b1, 1'b0);
        lit("ro_store_fault", 32'(c_resp_fault), 32'(e_fault), 32'd1);
        lit("ro_store_pa", c_resp_paddr, e_pa, 32'h2A123);
        access(32'h0000_7123, 1'b0, 1'b0);
        lit("ro_load_fault", 32'(c_resp_fault), 32'(e_fault), 32'd0);

        // Flush wins over a simultaneous refill
        access(32'h0000_9000, 1'b0, 1'b0);
        flush = 1'b1; refill_valid = 1'b1; refill_ppn = 20'h33; refill_wr = 1'b1;
        cyc();
        flush = 1'b0; refill_valid = 1'b0;
        lit("flush_miss_valid", 32'(c_miss_valid), 32'(e_mv), 32'd0);
        lit("flush_no_resp", 32'(c_resp_valid), 32'(e_rv), 32'd0);
        lit("flush_fetch", 32'(c_fetch), 32'(e_fetch), 32'd1);
        access(32'h0000_7123, 1'b0, 1'b0);
        lit("after_flush_miss", 32'(c_miss_valid), 32'(e_mv), 32'd1);
        refill(20'h2B, 1'b1);
        cyc();

        // Asynchronous reset while a miss is pending
        access(32'h0000_B000, 1'b0, 1'b0);
        chk("pre_reset_miss", 32'(c_miss_valid), 32'd1);
        #1;
        reset = 1'b0;
        m_init();
        #1;
        chk("async_miss_valid", 32'(c_miss_valid), 32'd0);
        chk("async_fetch", 32'(c_fetch), 32'd1);
        chk("async_resp_valid", 32'(c_resp_valid), 32'd0);
        chk("async_paddr", c_resp_paddr, 32'd0);
        chk("async_miss_vpn", 32'(c_miss_vpn), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        rand_run(3000);

        // Larger configuration
        sel = 1'b1;
        do_reset();
        fill_replace(8, 20'hA5000);
        access(32'hFEDC_BA98, 1'b0, 1'b1);
        lit("b_sup_pa", c_resp_paddr, e_pa, 32'hFEDC_BA98);
        rand_run(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
